// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and launch-FSM state encoding for uart_tx_fifo.
// CR_PEND is only reachable when UART_TX_FIFO_CRLF_EN is defined.
package uart_tx_fifo_pkg;

    localparam logic [7:0] ASCII_CR          = 8'h0D;
    localparam logic [7:0] ASCII_LF          = 8'h0A;
    localparam int         WAIT_BUSY_TIMEOUT = 4;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LAUNCH,
        WAIT_BUSY,
        WAIT_READY,
        CR_PEND
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock circular FIFO: RAM, wrapping pointers, occupancy count and
// flags derived from the registered count, plus a sticky overflow flag.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage has no reset; only locations behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Full is judged at the start of the cycle, so a same-cycle pop
            // does not rescue the write.
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding uart_tx over its i_en/o_ready handshake.
// Optional UART_TX_FIFO_CRLF_EN: a popped LF goes out as CR then LF.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int p_DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [7:0]            i8_wr_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [p_DEPTH_LOG2:0] o_count,
    output logic                  o_overflow,
    output logic                  o_tx_en,
    output logic [7:0]            o8_txdata,
    input  logic                  i_tx_ready,
    output logic                  o_busy
);

    tx_state_t  state;
    tx_state_t  next_state;
    logic       pop;
    logic [7:0] rd_data;
    logic [2:0] wait_cnt;
`ifdef UART_TX_FIFO_CRLF_EN
    logic       lf_pend;
`endif

    sync_fifo #(
        .DEPTH_LOG2 (p_DEPTH_LOG2),
        .WIDTH      (8)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .wr_en    (i_wr_en),
        .wr_data  (i8_wr_data),
        .rd_en    (pop),
        .rd_data  (rd_data),
        .full     (o_full),
        .empty    (o_empty),
        .count    (o_count),
        .overflow (o_overflow)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!o_empty && i_tx_ready) begin
                    next_state = POP;
                    pop        = 1'b1;
                end
            end
            POP:       next_state = LAUNCH;
            LAUNCH:    next_state = WAIT_BUSY;
            // uart_tx may finish (or never drop ready) before we see it busy.
            WAIT_BUSY: begin
                if (!i_tx_ready || wait_cnt == 3'(WAIT_BUSY_TIMEOUT - 1))
                    next_state = WAIT_READY;
            end
            WAIT_READY: begin
                if (i_tx_ready) begin
`ifdef UART_TX_FIFO_CRLF_EN
                    next_state = lf_pend ? CR_PEND : IDLE;
`else
                    next_state = IDLE;
`endif
                end
            end
`ifdef UART_TX_FIFO_CRLF_EN
            CR_PEND:   next_state = LAUNCH;
`endif
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o8_txdata <= 8'h00;
            wait_cnt  <= '0;
        end else begin
            wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + 3'd1 : 3'd0;
            if (pop) begin
`ifdef UART_TX_FIFO_CRLF_EN
                o8_txdata <= (rd_data == ASCII_LF) ? ASCII_CR : rd_data;
`else
                o8_txdata <= rd_data;
`endif
            end
`ifdef UART_TX_FIFO_CRLF_EN
            else if (next_state == CR_PEND) begin
                o8_txdata <= ASCII_LF;
            end
`endif
        end
    end

`ifdef UART_TX_FIFO_CRLF_EN
    // Remembers that the CR just launched still owes the held LF.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            lf_pend <= 1'b0;
        else if (pop)
            lf_pend <= (rd_data == ASCII_LF);
        else if (next_state == CR_PEND)
            lf_pend <= 1'b0;
    end
`endif

    assign o_tx_en = (state == LAUNCH);
    assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural uart_tx stand-in that
// records every launched byte and holds ready low for a short frame.
module tb_uart_tx_fifo;

    localparam int FRAME = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, tx_en, busy;
    logic [4:0] count;
    logic [7:0] txdata;
    logic       tx_ready;

    logic       m_ready;
    logic       stall = 1'b0;
    logic       fast = 1'b0;
    int         frame_left;
    int         glitches = 0;
    int         cyc = 0;
    logic [7:0] held;
    logic [7:0] rx_q[$];

    int n_cmp = 0;
    int n_err = 0;

    assign tx_ready = m_ready && !stall;

    uart_tx_fifo #(.p_DEPTH_LOG2(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i8_wr_data (wr_data),
        .o_full     (full),
        .o_empty    (empty),
        .o_count    (count),
        .o_overflow (overflow),
        .o_tx_en    (tx_en),
        .o8_txdata  (txdata),
        .i_tx_ready (tx_ready),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in: latch byte on en, drop ready for FRAME cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready    <= 1'b1;
            frame_left <= 0;
            held       <= 8'h00;
        end else if (frame_left != 0) begin
            if (txdata !== held)
                glitches <= glitches + 1;
            frame_left <= frame_left - 1;
            if (frame_left == 1)
                m_ready <= 1'b1;
        end else if (tx_en) begin
            rx_q.push_back(txdata);
            held <= txdata;
            if (!fast) begin
                m_ready    <= 1'b0;
                frame_left <= FRAME;
            end
        end
    end

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!(empty && !busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout waiting for idle, count=%0d busy=%0b", tag, count, busy);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (full !== 1'b0 || busy !== 1'b0 || txdata !== 8'h00) begin
            n_err++; $display("FAIL reset_misc: full=%b busy=%b txdata=%h want 0/0/00", full, busy, txdata);
        end
    endtask

    task automatic test_single();
        rx_q.delete();
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h21;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (count !== 5'd1 || tx_en !== 1'b0) begin
            n_err++; $display("FAIL single_n0: count=%0d tx_en=%b want 1/0", count, tx_en);
        end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || count !== 5'd0 || txdata !== 8'h21 || tx_en !== 1'b0) begin
            n_err++; $display("FAIL single_pop: busy=%b count=%0d txdata=%h tx_en=%b want 1/0/21/0", busy, count, txdata, tx_en);
        end
        @(negedge clk);
        n_cmp++; if (tx_en !== 1'b1) begin n_err++; $display("FAIL single_launch: tx_en=%b want 1", tx_en); end
        @(negedge clk);
        n_cmp++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: tx_en=%b want 0", tx_en); end
        wait_idle("single");
        n_cmp++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h21) begin
            n_err++; $display("FAIL single_rx: size=%0d want 1 byte 21", rx_q.size());
        end
    endtask

    task automatic test_burst();
        rx_q.delete();
        stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) begin
                n_cmp++; if (full !== 1'b0 || count !== 5'd15) begin
                    n_err++; $display("FAIL burst_15: full=%b count=%0d want 0/15", full, count);
                end
            end
            wr_en = 1'b1; wr_data = 8'h41 + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            n_err++; $display("FAIL burst_full: full=%b count=%0d ovf=%b want 1/16/0", full, count, overflow);
        end
        stall = 1'b0;
        wait_idle("burst");
        n_cmp++; if (rx_q.size() !== 16) begin n_err++; $display("FAIL burst_rx_size: got %0d want 16", rx_q.size()); end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== 8'h41 + 8'(i)) begin
                n_err++; $display("FAIL burst_rx[%0d]: got %h want %h", i, rx_q[i], 8'h41 + 8'(i));
            end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL burst_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        rx_q.delete();
        stall = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        n_cmp++; if (full !== 1'b1 || overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_pre: full=%b ovf=%b want 1/0", full, overflow);
        end
        // Write while full in the same cycle as a pop: must still drop.
        @(negedge clk);
        stall = 1'b0;
        wr_en = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (count !== 5'd15 || overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_drop: count=%0d ovf=%b want 15/1", count, overflow);
        end
        wait_idle("overflow");
        n_cmp++; if (rx_q.size() !== 16) begin n_err++; $display("FAIL ovf_rx_size: got %0d want 16", rx_q.size()); end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== 8'h80 + 8'(i)) begin
                n_err++; $display("FAIL ovf_rx[%0d]: got %h want %h", i, rx_q[i], 8'h80 + 8'(i));
            end
        end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        int k;
        rx_q.delete();
        stall = 1'b1;
        push(8'h31);
        push(8'h32);
        stall = 1'b0;
        k = 0;
        while (busy !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        n_cmp++; if (k >= 200 || txdata !== 8'h31 || count !== 5'd1) begin
            n_err++; $display("FAIL b2b_idle: k=%0d txdata=%h count=%0d want <200/31/1", k, txdata, count);
        end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || txdata !== 8'h32 || count !== 5'd0) begin
            n_err++; $display("FAIL b2b_repop: busy=%b txdata=%h count=%0d want 1/32/0", busy, txdata, count);
        end
        wait_idle("b2b");
        n_cmp++; if (rx_q.size() !== 2 || rx_q[0] !== 8'h31 || rx_q[1] !== 8'h32) begin
            n_err++; $display("FAIL b2b_rx: size=%0d want 2 bytes 31,32", rx_q.size());
        end
    endtask

    task automatic test_wrap();
        int sent;
        int k;
        rx_q.delete();
        stall = 1'b1;
        for (int i = 0; i < 15; i++) push(8'h60 + 8'(i));
        sent = 15;
        k = 0;
        @(negedge clk);
        stall = 1'b0;
        while (sent < 40 && k < 5000) begin
            if (!busy && m_ready && !empty) begin
                wr_en = 1'b1; wr_data = 8'h60 + 8'(sent);
                sent++;
                @(negedge clk);
                wr_en = 1'b0;
                n_cmp++; if (count !== 5'd15) begin
                    n_err++; $display("FAIL wrap_count@%0d: got %0d want 15", sent, count);
                end
            end else begin
                @(negedge clk);
            end
            k++;
        end
        if (k >= 5000) begin n_cmp++; n_err++; $display("FAIL wrap_feed: timeout, sent=%0d want 40", sent); end
        wait_idle("wrap");
        n_cmp++; if (rx_q.size() !== 40) begin n_err++; $display("FAIL wrap_rx_size: got %0d want 40", rx_q.size()); end
        for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== 8'h60 + 8'(i)) begin
                n_err++; $display("FAIL wrap_rx[%0d]: got %h want %h", i, rx_q[i], 8'h60 + 8'(i));
            end
        end
    endtask

    task automatic test_timeout();
        int t[2];
        int n = 0;
        rx_q.delete();
        fast = 1'b1;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h51;
        @(negedge clk);
        wr_data = 8'h52;
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx_en && n < 2) begin t[n] = cyc; n++; end
            @(negedge clk);
        end
        n_cmp++; if (n !== 2 || t[1] - t[0] !== 8) begin
            n_err++; $display("FAIL timeout_gap: launches=%0d gap=%0d want 2/8", n, t[1] - t[0]);
        end
        wait_idle("timeout");
        fast = 1'b0;
        n_cmp++; if (rx_q.size() !== 2 || rx_q[0] !== 8'h51 || rx_q[1] !== 8'h52) begin
            n_err++; $display("FAIL timeout_rx: size=%0d want 2 bytes 51,52", rx_q.size());
        end
    endtask

    task automatic test_crlf();
        logic [7:0] exp[$];
        rx_q.delete();
`ifdef UART_TX_FIFO_CRLF_EN
        exp = '{8'h41, 8'h0D, 8'h0A};
`else
        exp = '{8'h41, 8'h0A};
`endif
        push(8'h41);
        push(8'h0A);
        wait_idle("crlf");
        n_cmp++; if (rx_q.size() !== exp.size()) begin
            n_err++; $display("FAIL crlf_size: got %0d want %0d", rx_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp[i]) begin
                n_err++; $display("FAIL crlf_rx[%0d]: got %h want %h", i, rx_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        push(8'h77);
        push(8'h78);
        n_cmp++; if (busy !== 1'b1 || count !== 5'd1) begin
            n_err++; $display("FAIL arst_pre: busy=%b count=%0d want 1/1", busy, count);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || tx_en !== 1'b0 || txdata !== 8'h00) begin
            n_err++; $display("FAIL arst_clear: busy=%b count=%0d empty=%b tx_en=%b txdata=%h want 0/0/1/0/00",
                              busy, count, empty, tx_en, txdata);
        end
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_crlf();
        n_cmp++; if (glitches !== 0) begin
            n_err++; $display("FAIL txdata_stable: changes during frame=%0d want 0", glitches);
        end
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
